sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single 16-bit off-chip SRAM between two 32-bit requesters.
  - Port 0: the CPU memory stage.
  - Port 1: the program loader / debug port.
- Each granted 32-bit word access is sequenced as two 16-bit half accesses with programmable wait states.
- Drives the SRAM pins directly and returns a stall-compatible ready to the pipeline.

Parameters:
- WAIT_CYCLES, 2, SRAM cycles held per 16-bit half access; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 access request; held until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  32  port 0 byte address; bits [18:2] used.
- wdata0  in  32  port 0 write data.
- ready0  out  1  port 0 ready: high when req0 is low or ack0 is high (pipeline freeze = ~ready0).
- ack0  out  1  one-cycle completion pulse for port 0.
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1.
- rdata  out  32  read data of the last completed read (either port).
- busy  out  1  FSM not in IDLE.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  SRAM controls, active-low.

Behaviour:
- Reset (async, any state): state=IDLE; ack0=ack1=0; rdata=0; busy=0; SRAM_WE_N=SRAM_OE_N=SRAM_CE_N=1; SRAM_UB_N=SRAM_LB_N=0; SRAM_ADDR=0; SRAM_DQ high-Z; wait counter=0; RR pointer=0.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If any req is high: grant, latch we/addr/wdata/port id, go to LOW.
  - Otherwise stay in IDLE.
- LOW: WAIT_CYCLES cycles.
  - SRAM_ADDR = {addr[18:2],1'b0}; CE_N=0.
  - Write: WE_N=0, DQ=wdata[15:0].
  - Read: OE_N=0, DQ high-Z; rdata[15:0] captured on the last LOW cycle.
- HIGH: same as LOW with SRAM_ADDR = {addr[18:2],1'b1}, data bits [31:16].
- DONE: one cycle; ack of the granted port = 1; next state IDLE.
- Latency: req sampled high at edge N leaves ack high during cycle N+2*WAIT_CYCLES+1; default 5 cycles.
- Back-to-back: DONE→IDLE always, so at least one IDLE cycle separates grants; a req still high in IDLE is treated as a new request.
- Arbitration (no macro): fixed priority; port 0 wins simultaneous requests.
- Latched operands: req/addr/wdata changes after grant are ignored. A req dropped mid-transaction does not abort it; ack still pulses.
- rdata: holds its value until the next read completes. A write never alters rdata.
- WE_N and OE_N are never low in the same cycle; DQ is driven only while WE_N=0.
- Wait counter is 4 bits and resets on every half boundary.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer names the preferred port on simultaneous requests and flips to the other port after each grant to the preferred port. A sole requester is always granted.
- Undefined: fixed priority with port 0 highest; pointer logic absent.

Test Plan:
- Reset during HIGH of a port 0 write → next cycle: CE_N=WE_N=1, DQ=Z, busy=0, no ack.
- Port 0 write addr0=0x0000_0010, wdata0=0xDEAD_BEEF, WAIT_CYCLES=2:
  - Cycles 1-2: SRAM_ADDR=0x00008, DQ=0xBEEF, WE_N=0.
  - Cycles 3-4: SRAM_ADDR=0x00009, DQ=0xDEAD.
  - Cycle 5: ack0=1, ready0=1.
- Port 1 read of addr1=0x10 after the above, SRAM model returning stored halves → ack1 at cycle 5, rdata=0xDEADBEEF, ack0 stays 0.
- req0 and req1 both held high continuously:
  - Fixed: port 0 granted every transaction, port 1 starves.
  - SRAM_ARB_RR_EN: grants alternate 0,1,0,1.
- req0 high one cycle then dropped → full transaction runs, ack0 pulses at cycle 5, FSM returns to IDLE.
- WAIT_CYCLES=1: ack at cycle 3. WAIT_CYCLES=15: ack at cycle 31. In both cases, checker confirms WE_N/OE_N are never low together.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit asynchronous SRAM between two 32-bit requesters.
// Each granted word access runs as a low half then a high half, each held for
// WAIT_CYCLES clocks, followed by a one-cycle DONE state that pulses the ack.
//
// Optional feature: define SRAM_ARB_RR_EN for round-robin arbitration between
// the two ports; when undefined, port 0 has fixed priority.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req/we/addr/wdata 0 and 1    requester inputs (req held until ack)
//   ready0/ready1                combinational stall release (~req | ack)
//   ack0/ack1                    one-cycle completion pulses
//   rdata                        data of the last completed read
//   busy                         controller not idle
//   SRAM_*                       SRAM pins, controls active-low, DQ bidirectional
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ready0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ready1,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        busy,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last_cycle;

  logic               lat_port, lat_we;
  logic [16:0]        lat_addr;
  logic [31:0]        lat_wdata;
  logic [15:0]        rdata_lo;
  logic [15:0]        dq_out;

  logic               grant_port;
  logic               op_port, op_we;
  logic [16:0]        op_addr;
  logic [31:0]        op_wdata;

  logic [17:0]        addr_nxt;
  logic [15:0]        dq_nxt;
  logic               ce_n_nxt, we_n_nxt, oe_n_nxt, ack0_nxt, ack1_nxt, busy_nxt;

  // Only word-address bits [18:2] reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[31:19], addr0[1:0], addr1[31:19], addr1[1:0]};

  // Port selection for a request seen in IDLE.
`ifdef SRAM_ARB_RR_EN
  logic ptr;
  assign grant_port = (req0 && req1) ? ptr : req1;
`else
  assign grant_port = !req0;
`endif

  // Operands: live inputs at grant time, latched copies afterwards.
  assign op_port  = (state == IDLE) ? grant_port : lat_port;
  assign op_we    = (state == IDLE) ? (grant_port ? we1 : we0) : lat_we;
  assign op_addr  = (state == IDLE) ? (grant_port ? addr1[18:2] : addr0[18:2]) : lat_addr;
  assign op_wdata = (state == IDLE) ? (grant_port ? wdata1 : wdata0) : lat_wdata;

  assign last_cycle = (cnt == CNT_LAST);

  assign ready0 = !req0 || ack0;
  assign ready1 = !req1 || ack1;

  // Data bus is driven only during write halves.
  assign SRAM_DQ = SRAM_WE_N ? 16'bz : dq_out;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and wait counter; counter restarts at every half boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: if (req0 || req1) state_nxt = LOW;
      LOW:  if (last_cycle) state_nxt = HIGH; else cnt_nxt = cnt + CNT_W'(1);
      HIGH: if (last_cycle) state_nxt = DONE; else cnt_nxt = cnt + CNT_W'(1);
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin values for the upcoming cycle, decoded from the next state.
  always_comb begin
    addr_nxt = SRAM_ADDR;
    dq_nxt   = dq_out;
    ce_n_nxt = 1'b1;
    we_n_nxt = 1'b1;
    oe_n_nxt = 1'b1;
    ack0_nxt = 1'b0;
    ack1_nxt = 1'b0;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      LOW, HIGH: begin
        addr_nxt = {op_addr, state_nxt == HIGH};
        dq_nxt   = (state_nxt == HIGH) ? op_wdata[31:16] : op_wdata[15:0];
        ce_n_nxt = 1'b0;
        we_n_nxt = !op_we;
        oe_n_nxt = op_we;
      end
      DONE: begin
        ack0_nxt = !op_port;
        ack1_nxt = op_port;
      end
      default: ;
    endcase
  end

  // Registered pins, operand latch and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_UB_N <= 1'b0;
      SRAM_LB_N <= 1'b0;
      dq_out    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      rdata_lo  <= '0;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      SRAM_ADDR <= addr_nxt;
      SRAM_CE_N <= ce_n_nxt;
      SRAM_WE_N <= we_n_nxt;
      SRAM_OE_N <= oe_n_nxt;
      SRAM_UB_N <= 1'b0;
      SRAM_LB_N <= 1'b0;
      dq_out    <= dq_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      busy      <= busy_nxt;
      if (state == IDLE && state_nxt == LOW) begin
        lat_port  <= op_port;
        lat_we    <= op_we;
        lat_addr  <= op_addr;
        lat_wdata <= op_wdata;
      end
      // Low half is staged so rdata changes only when the whole read completes.
      if (state == LOW && last_cycle && !lat_we) rdata_lo <= SRAM_DQ;
      if (state == HIGH && last_cycle && !lat_we) rdata <= {SRAM_DQ, rdata_lo};
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Preference moves away from a port once it has been granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= 1'b0;
    else if (state == IDLE && (req0 || req1) && grant_port == ptr) ptr <= !ptr;
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT (WAIT_CYCLES = 2) with an SRAM model.
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic        ready0, ack0, ready1, ack1, busy;
  logic [31:0] rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ready0(ready0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ready1(ready1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  logic [15:0] mem [0:255];
  logic [15:0] mem_rd;
  assign mem_rd  = mem[sram_addr[7:0]];
  assign sram_dq = (!ce_n && !oe_n) ? mem_rd : 16'bz;
  always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq;

  // Latency DUTs at the wait-state extremes, sharing one port-0 stimulus.
  logic        reqx = 0, wex = 0;
  logic [31:0] addrx = 32'h10, wdatax = 32'h1234_5678;
  logic        ack_w1, ack_w15, busy_w1, busy_w15;
  logic        we_n_w1, oe_n_w1, we_n_w15, oe_n_w15;
  logic        unused_r0_w1, unused_r1_w1, unused_a1_w1, unused_ce_w1, unused_ub_w1, unused_lb_w1;
  logic        unused_r0_w15, unused_r1_w15, unused_a1_w15, unused_ce_w15, unused_ub_w15, unused_lb_w15;
  logic [31:0] unused_rd_w1, unused_rd_w15;
  logic [17:0] unused_ad_w1, unused_ad_w15;
  wire  [15:0] dq_w1, dq_w15;

  sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .req0(reqx), .we0(wex), .addr0(addrx), .wdata0(wdatax), .ready0(unused_r0_w1), .ack0(ack_w1),
    .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0), .ready1(unused_r1_w1), .ack1(unused_a1_w1),
    .rdata(unused_rd_w1), .busy(busy_w1), .SRAM_DQ(dq_w1), .SRAM_ADDR(unused_ad_w1),
    .SRAM_UB_N(unused_ub_w1), .SRAM_LB_N(unused_lb_w1), .SRAM_WE_N(we_n_w1), .SRAM_CE_N(unused_ce_w1),
    .SRAM_OE_N(oe_n_w1)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst),
    .req0(reqx), .we0(wex), .addr0(addrx), .wdata0(wdatax), .ready0(unused_r0_w15), .ack0(ack_w15),
    .req1(1'b0), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0), .ready1(unused_r1_w15), .ack1(unused_a1_w15),
    .rdata(unused_rd_w15), .busy(busy_w15), .SRAM_DQ(dq_w15), .SRAM_ADDR(unused_ad_w15),
    .SRAM_UB_N(unused_ub_w15), .SRAM_LB_N(unused_lb_w15), .SRAM_WE_N(we_n_w15), .SRAM_CE_N(unused_ce_w15),
    .SRAM_OE_N(oe_n_w15)
  );

  // Scoreboard: one entry per expected ack, in grant order.
  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow [0:63];
  logic [31:0] tb_rdata = 0;
  int          tb_ptr = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arbiter: returns the granted port and advances the RR pointer.
  function automatic int pick(input bit r0, input bit r1);
    int p;
`ifdef SRAM_ARB_RR_EN
    p = (r0 && r1) ? tb_ptr : (r1 ? 1 : 0);
    if (p == tb_ptr) tb_ptr = 1 - tb_ptr;
`else
    p = r0 ? 0 : 1;
`endif
    return p;
  endfunction

  task automatic push(input int port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int ack_cyc);
    exp_t e;
    if (we) shadow[addr[7:2]] = wdata;
    e.port    = port;
    e.rd      = !we;
    e.data    = shadow[addr[7:2]];
    e.ack_cyc = ack_cyc;
    sb.push_back(e);
  endtask

  task automatic set_port(input int port, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin req0 = req; we0 = we; addr0 = addr; wdata0 = wdata; end
    else           begin req1 = req; we1 = we; addr1 = addr; wdata1 = wdata; end
  endtask

  // One isolated transaction, request held until its ack.
  task automatic do_txn(input int port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    @(posedge clk) #1;
    void'(pick(port == 0, port == 1));
    push(port, we, addr, wdata, cyc + 5);
    set_port(port, 1'b1, we, addr, wdata);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk) #1;
      if ((port == 0) ? ack0 : ack1) got = 1;
    end
    set_port(port, 1'b0, we, addr, wdata);
    check("ack_seen", 32'(got), 32'd1);
  endtask

  // Ack monitor and read/write exclusivity checks, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) tb_rdata = 0;
    else begin
      if (ack0 || ack1) begin
        if (sb.size() == 0) check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
        else begin
          e = sb.pop_front();
          check("ack0", 32'(ack0), 32'(e.port == 0));
          check("ack1", 32'(ack1), 32'(e.port == 1));
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          if (e.rd) begin
            check("rdata", rdata, e.data);
            tb_rdata = e.data;
          end else check("rdata_hold", rdata, tb_rdata);
          if (e.port == 0) check("ready0_on_ack", 32'(ready0), 32'd1);
        end
      end
      if (!we_n || !oe_n)         check("we_oe_excl", 32'(we_n | oe_n), 32'd1);
      if (!we_n_w1 || !oe_n_w1)   check("we_oe_excl_w1", 32'(we_n_w1 | oe_n_w1), 32'd1);
      if (!we_n_w15 || !oe_n_w15) check("we_oe_excl_w15", 32'(we_n_w15 | oe_n_w15), 32'd1);
    end
  end

  initial begin
    int c0, acks, a1, a15, p;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ctl", {27'd0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'b11100);
    check("rst_addr", 32'(sram_addr), 32'd0);
    rst = 0;

    // Reset asserted while the high half of a write is in progress.
    @(posedge clk) #1;
    set_port(0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_addr", 32'(sram_addr), 32'h21);
    rst = 1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_mid_ctl", {30'd0, ce_n, we_n}, 32'b11);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk) #1;
    check("rst_mid_ack0", 32'(ack0), 32'd0);
    tb_ptr = 0;
    rst = 0;

    // Port 0 write with pin-level checks on each of the four half cycles.
    @(posedge clk) #1;
    void'(pick(1, 0));
    push(0, 1, 32'h10, 32'hDEAD_BEEF, cyc + 5);
    set_port(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk) #1;
      check("wr_addr", 32'(sram_addr), (k <= 2) ? 32'h8 : 32'h9);
      check("wr_dq", {16'd0, sram_dq}, (k <= 2) ? 32'hBEEF : 32'hDEAD);
      check("wr_ctl", {29'd0, ce_n, we_n, oe_n}, 32'b001);
      if (k == 1) check("ready0_stall", 32'(ready0), 32'd0);
    end
    @(posedge clk) #1;
    check("wr_ack0", 32'(ack0), 32'd1);
    check("wr_ready0", 32'(ready0), 32'd1);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reads and writes from both ports.
    do_txn(1, 0, 32'h10, 32'h0);
    do_txn(0, 1, 32'h24, 32'hCAFE_0123);
    do_txn(0, 0, 32'h24, 32'h0);
    do_txn(1, 1, 32'h30, 32'h0BAD_F00D);
    do_txn(0, 0, 32'h30, 32'h0);

    // Request held for a single cycle still completes.
    @(posedge clk) #1;
    void'(pick(1, 0));
    push(0, 1, 32'h44, 32'h55AA_33CC, cyc + 5);
    set_port(0, 1'b1, 1'b1, 32'h44, 32'h55AA_33CC);
    @(posedge clk) #1;
    set_port(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    acks = 0;
    for (int i = 0; i < 20 && acks == 0; i++) begin
      @(posedge clk) #1;
      if (ack0) acks = 1;
    end
    check("drop_ack_seen", 32'(acks), 32'd1);
    @(posedge clk) #1;
    check("drop_idle", 32'(busy), 32'd0);
    do_txn(1, 0, 32'h44, 32'h0);

    // Both ports requesting continuously for four grants.
    @(posedge clk) #1;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      p = pick(1, 1);
      push(p, 1, (p == 1) ? 32'h64 : 32'h60, (p == 1) ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0, c0 + 5 + 6 * k);
    end
    set_port(0, 1'b1, 1'b1, 32'h60, 32'hA0A0_A0A0);
    set_port(1, 1'b1, 1'b1, 32'h64, 32'hB1B1_B1B1);
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(posedge clk) #1;
      if (ack0 || ack1) acks++;
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("contention_acks", 32'(acks), 32'd4);
    do_txn(0, 0, 32'h60, 32'h0);
    do_txn(0, 0, 32'h64, 32'h0);

    // Latency at WAIT_CYCLES = 1 and 15, for a write then a read.
    for (int r = 0; r < 2; r++) begin
      @(posedge clk) #1;
      c0 = cyc;
      wex = (r == 0);
      reqx = 1;
      @(posedge clk) #1;
      reqx = 0;
      a1 = 0;
      a15 = 0;
      for (int i = 0; i < 40 && a15 == 0; i++) begin
        @(posedge clk) #1;
        if (ack_w1 && a1 == 0) a1 = cyc;
        if (ack_w15 && a15 == 0) a15 = cyc;
      end
      check("w1_latency", 32'(a1), 32'(c0 + 3));
      check("w15_latency", 32'(a15), 32'(c0 + 31));
      @(posedge clk) #1;
      check("w_extremes_idle", {30'd0, busy_w1, busy_w15}, 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
